// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-computing datapath.
//   SC_OUT_WIDTH : default bitstream word width, shared with the multiplier.
//   sc_state_e   : accumulator FSM states.
//   pop_width()  : number of bits needed to hold a popcount of a w-bit word.
// -----------------------------------------------------------------------------
package sc_pkg;

   localparam int SC_OUT_WIDTH = 32;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } sc_state_e;

   // A w-bit word has between 0 and w ones, so w+1 distinct values.
   function automatic int pop_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sc_bs_accumulator_if.sv
// -----------------------------------------------------------------------------
// sc_bs_accumulator_if
// Bitstream input and result output handshakes of the accumulator.
//   in_valid/in_ready/in_bs/in_last         : one bitstream word per accept
//   out_valid/out_ready/out_count/out_words/out_sat : one result per stream
// Modports:
//   master : upstream producer + downstream consumer side
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface sc_bs_accumulator_if
   import sc_pkg::*;
#(
   parameter int OUT_WIDTH = SC_OUT_WIDTH,
   parameter int CNT_WIDTH = 16,
   parameter int LEN_WIDTH = 8
);

   logic                 in_valid;
   logic                 in_ready;
   logic [OUT_WIDTH-1:0] in_bs;
   logic                 in_last;

   logic                 out_valid;
   logic                 out_ready;
   logic [CNT_WIDTH-1:0] out_count;
   logic [LEN_WIDTH-1:0] out_words;
   logic                 out_sat;

   modport master (
      output in_valid, in_bs, in_last, out_ready,
      input  in_ready, out_valid, out_count, out_words, out_sat
   );

   modport slave (
      input  in_valid, in_bs, in_last, out_ready,
      output in_ready, out_valid, out_count, out_words, out_sat
   );

endinterface

// File: rtl/sc_popcount.sv
// -----------------------------------------------------------------------------
// sc_popcount
// Combinational ones-count of a bitstream word using a balanced adder tree.
//   bits  [OUT_WIDTH-1:0] : input word
//   count [PW-1:0]        : number of ones in bits (0..OUT_WIDTH)
// -----------------------------------------------------------------------------
module sc_popcount
   import sc_pkg::*;
#(
   parameter  int OUT_WIDTH = SC_OUT_WIDTH,
   localparam int PW        = pop_width(OUT_WIDTH)
) (
   input  logic [OUT_WIDTH-1:0] bits,
   output logic [PW-1:0]        count
);

   // Leaves padded up to a power of two so the tree is a complete heap:
   // node i has children 2i+1 and 2i+2, leaves occupy LEAVES-1 .. 2*LEAVES-2.
   localparam int LEAVES = 1 << $clog2(OUT_WIDTH);

   logic [PW-1:0] node [2*LEAVES-1];

   // Every partial sum is bounded by OUT_WIDTH, so PW bits suffice at every
   // level of the tree.
   always_comb begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
         node[LEAVES - 1 + i] = PW'(bits[i]);
      end
      for (int i = OUT_WIDTH; i < LEAVES; i++) begin
         node[LEAVES - 1 + i] = '0;
      end
      for (int i = LEAVES - 2; i >= 0; i--) begin
         node[i] = node[2*i + 1] + node[2*i + 2];
      end
   end

   assign count = node[0];

endmodule

// File: rtl/sc_bs_accumulator.sv
// -----------------------------------------------------------------------------
// sc_bs_accumulator
// Stochastic-to-binary back end. Accumulates the ones-count and word count of
// a multi-word bitstream delimited by in_last, then presents the saturating
// totals on a valid/ready result port.
// Ports:
//   clk   : single clock, rising edge
//   rst   : synchronous active-high reset
//   flush : synchronous abort of the current stream and any pending result
//   bus   : sc_bs_accumulator_if.slave
//           input  word handshake  (in_valid, in_ready, in_bs, in_last)
//           result handshake       (out_valid, out_ready, out_count,
//                                   out_words, out_sat)
// -----------------------------------------------------------------------------
module sc_bs_accumulator
   import sc_pkg::*;
#(
   parameter int OUT_WIDTH = SC_OUT_WIDTH,
   parameter int CNT_WIDTH = 16,
   parameter int LEN_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   sc_bs_accumulator_if.slave  bus
);

   localparam int PW = pop_width(OUT_WIDTH);

   // Saturating add returning {overflow, clamped_sum}; the sum is formed one
   // bit wider so the carry out is the overflow indicator.
   function automatic logic [CNT_WIDTH:0] sat_add_cnt(
      input logic [CNT_WIDTH-1:0] a,
      input logic [PW-1:0]        b
   );
      logic [CNT_WIDTH:0] wide;
      wide = {1'b0, a} + (CNT_WIDTH + 1)'(b);
      if (wide[CNT_WIDTH]) begin
         sat_add_cnt = {1'b1, {CNT_WIDTH{1'b1}}};
      end else begin
         sat_add_cnt = wide;
      end
   endfunction

   function automatic logic [LEN_WIDTH:0] sat_inc_len(
      input logic [LEN_WIDTH-1:0] a
   );
      logic [LEN_WIDTH:0] wide;
      wide = {1'b0, a} + (LEN_WIDTH + 1)'(1);
      if (wide[LEN_WIDTH]) begin
         sat_inc_len = {1'b1, {LEN_WIDTH{1'b1}}};
      end else begin
         sat_inc_len = wide;
      end
   endfunction

   sc_state_e            state_q,     state_d;
   logic [CNT_WIDTH-1:0] acc_q,       acc_d;
   logic [LEN_WIDTH-1:0] words_q,     words_d;
   logic                 sat_flag_q,  sat_flag_d;
   logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
   logic [LEN_WIDTH-1:0] out_words_q, out_words_d;
   logic                 out_sat_q,   out_sat_d;

   logic                 accept;
   logic [OUT_WIDTH-1:0] bs_gated;
   logic [PW-1:0]        pop_cnt;
   logic                 acc_ovf;
   logic [CNT_WIDTH-1:0] acc_sum;
   logic                 len_ovf;
   logic [LEN_WIDTH-1:0] len_sum;
   logic                 sat_next;

   assign accept = bus.in_valid && (state_q == ST_ACCUM);

   // Unaccepted words (possibly X while in_valid=0) never reach the adders.
   assign bs_gated = accept ? bus.in_bs : '0;

   sc_popcount #(
      .OUT_WIDTH (OUT_WIDTH)
   ) u_popcount (
      .bits  (bs_gated),
      .count (pop_cnt)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      words_d     = words_q;
      sat_flag_d  = sat_flag_q;
      out_count_d = out_count_q;
      out_words_d = out_words_q;
      out_sat_d   = out_sat_q;

      {acc_ovf, acc_sum} = sat_add_cnt(acc_q, pop_cnt);
      {len_ovf, len_sum} = sat_inc_len(words_q);
      sat_next           = sat_flag_q | acc_ovf | len_ovf;

      if (flush) begin
         // Abort wins over any same-cycle accept or result handshake.
         state_d    = ST_ACCUM;
         acc_d      = '0;
         words_d    = '0;
         sat_flag_d = 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (accept) begin
                  if (bus.in_last) begin
                     // Result takes the post-add values; the running state
                     // restarts so the next stream counts from zero.
                     out_count_d = acc_sum;
                     out_words_d = len_sum;
                     out_sat_d   = sat_next;
                     acc_d       = '0;
                     words_d     = '0;
                     sat_flag_d  = 1'b0;
                     state_d     = ST_HOLD;
                  end else begin
                     acc_d      = acc_sum;
                     words_d    = len_sum;
                     sat_flag_d = sat_next;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  state_d = ST_ACCUM;
               end
            end
            default: begin
               state_d = ST_ACCUM;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         words_q     <= '0;
         sat_flag_q  <= 1'b0;
         out_count_q <= '0;
         out_words_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         words_q     <= words_d;
         sat_flag_q  <= sat_flag_d;
         out_count_q <= out_count_d;
         out_words_q <= out_words_d;
         out_sat_q   <= out_sat_d;
      end
   end

   // Both handshake outputs are pure decodes of the registered state, so
   // there is no combinational path from out_ready to in_ready.
   assign bus.in_ready  = (state_q == ST_ACCUM);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_count = out_count_q;
   assign bus.out_words = out_words_q;
   assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sc_bs_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sc_bs_accumulator
// Self-checking bench for sc_bs_accumulator. A default-width instance covers
// the main behaviour; a CNT_WIDTH=6 instance covers count saturation.
// The reference model keeps the stream's true ones-total and word count as
// plain integers and clamps them once at the end of the stream.
// -----------------------------------------------------------------------------
module tb_sc_bs_accumulator;

   localparam int OW  = 32;
   localparam int CW  = 16;
   localparam int LW  = 8;
   localparam int CW6 = 6;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic flush6;

   always #5 clk = ~clk;

   sc_bs_accumulator_if #(.OUT_WIDTH(OW), .CNT_WIDTH(CW),  .LEN_WIDTH(LW)) bus  ();
   sc_bs_accumulator_if #(.OUT_WIDTH(OW), .CNT_WIDTH(CW6), .LEN_WIDTH(LW)) bus6 ();

   sc_bs_accumulator #(.OUT_WIDTH(OW), .CNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   sc_bs_accumulator #(.OUT_WIDTH(OW), .CNT_WIDTH(CW6), .LEN_WIDTH(LW)) dut6 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush6),
      .bus   (bus6)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: unclamped stream totals and the expected result.
   int m_total = 0;
   int m_n     = 0;
   int e_cnt;
   int e_words;
   bit e_sat;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_total = 0;
      m_n     = 0;
   endtask

   // Clamping once at the end equals clamping after every add, because all
   // increments are non-negative.
   task automatic model_finish(input int cw, input int lw);
      int cmax;
      int wmax;
      cmax    = (1 << cw) - 1;
      wmax    = (1 << lw) - 1;
      e_cnt   = (m_total > cmax) ? cmax : m_total;
      e_words = (m_n > wmax) ? wmax : m_n;
      e_sat   = (m_total > cmax) || (m_n > wmax);
      model_clear();
   endtask

   function automatic logic [OW-1:0] rand_word();
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) return '0;
      if (r == 1) return '1;
      return $urandom;
   endfunction

   task automatic send_word(input logic [OW-1:0] bs, input bit last);
      bus.in_valid = 1'b1;
      bus.in_bs    = bs;
      bus.in_last  = last;
      for (int k = 0; k < 30 && bus.in_ready !== 1'b1; k++) step();
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_wait in_ready=%b required 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_bs    = 'x;
      m_total += $countones(bs);
      m_n++;
      if (last) model_finish(CW, LW);
   endtask

   task automatic send_word6(input logic [OW-1:0] bs, input bit last);
      bus6.in_valid = 1'b1;
      bus6.in_bs    = bs;
      bus6.in_last  = last;
      for (int k = 0; k < 30 && bus6.in_ready !== 1'b1; k++) step();
      n_cmp++;
      if (bus6.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send6_wait in_ready=%b required 1", bus6.in_ready);
      end
      step();
      bus6.in_valid = 1'b0;
      bus6.in_last  = 1'b0;
      bus6.in_bs    = 'x;
      m_total += $countones(bs);
      m_n++;
      if (last) model_finish(CW6, LW);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready); end
      n_cmp++; if (bus.out_count !== 16'd0) begin n_fail++; $display("FAIL reset_out_count got %0d required 0", bus.out_count); end
      n_cmp++; if (bus.out_words !== 8'd0) begin n_fail++; $display("FAIL reset_out_words got %0d required 0", bus.out_words); end
      n_cmp++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got %b required 0", bus.out_sat); end
      n_cmp++; if (bus6.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset6_out_valid got %b required 0", bus6.out_valid); end
      rst = 1'b0;
      step();
      model_clear();
   endtask

   task automatic test_single_word();
      bus.out_ready = 1'b1;
      send_word(32'hFFFF_0000, 1'b1);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b required 1", bus.out_valid); end
      n_cmp++; if (bus.out_count !== 16'd16) begin n_fail++; $display("FAIL single_count got %0d required 16", bus.out_count); end
      n_cmp++; if (bus.out_words !== 8'd1) begin n_fail++; $display("FAIL single_words got %0d required 1", bus.out_words); end
      n_cmp++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL single_sat got %b required 0", bus.out_sat); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_release got %b required 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_word(32'hFFFF_FFFF, i == 3);
      n_cmp++; if (bus.out_count !== CW'(e_cnt)) begin n_fail++; $display("FAIL b2b_count got %0d required %0d", bus.out_count, e_cnt); end
      n_cmp++; if (bus.out_words !== LW'(e_words)) begin n_fail++; $display("FAIL b2b_words got %0d required %0d", bus.out_words, e_words); end
      // Fifth word offered in the result cycle: the block is in HOLD.
      bus.in_valid = 1'b1;
      bus.in_bs    = 32'h0000_00FF;
      bus.in_last  = 1'b1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble in_ready=%b required 0", bus.in_ready); end
      step();
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back in_ready=%b required 1", bus.in_ready); end
      send_word(32'h0000_00FF, 1'b1);
      n_cmp++; if (bus.out_count !== CW'(e_cnt) || bus.out_words !== LW'(e_words)) begin
         n_fail++; $display("FAIL b2b_fifth got %0d/%0d required %0d/%0d", bus.out_count, bus.out_words, e_cnt, e_words);
      end
      step();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      send_word(rand_word(), 1'b0);
      send_word(rand_word(), 1'b1);
      bus.in_valid = 1'b1;
      bus.in_bs    = 32'hFFFF_FFFF;
      bus.in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold cyc %0d valid=%b ready=%b required 1/0", c, bus.out_valid, bus.in_ready);
         end
         n_cmp++; if (bus.out_count !== CW'(e_cnt) || bus.out_words !== LW'(e_words) || bus.out_sat !== e_sat) begin
            n_fail++; $display("FAIL bp_stable cyc %0d got %0d/%0d/%b required %0d/%0d/%b", c, bus.out_count, bus.out_words, bus.out_sat, e_cnt, e_words, e_sat);
         end
         step();
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      step();
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
      end
      send_word(rand_word(), 1'b1);
      n_cmp++; if (bus.out_count !== CW'(e_cnt) || bus.out_words !== LW'(e_words)) begin
         n_fail++; $display("FAIL bp_next got %0d/%0d required %0d/%0d", bus.out_count, bus.out_words, e_cnt, e_words);
      end
      step();
   endtask

   task automatic test_random_streams();
      int  len;
      bit  done;
      for (int s = 0; s < 10; s++) begin
         len = $urandom_range(1, 6);
         for (int w = 0; w < len; w++) begin
            repeat ($urandom_range(0, 2)) step();
            send_word(rand_word(), w == len - 1);
         end
         done = 1'b0;
         for (int k = 0; k < 10 && !done; k++) begin
            bus.out_ready = (k >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_count !== CW'(e_cnt) || bus.out_words !== LW'(e_words) || bus.out_sat !== e_sat) begin
               n_fail++; $display("FAIL rand_result s%0d got v=%b %0d/%0d/%b required 1 %0d/%0d/%b", s, bus.out_valid, bus.out_count, bus.out_words, bus.out_sat, e_cnt, e_words, e_sat);
            end
            done = bus.out_ready;
            step();
         end
         n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_release s%0d got %b required 0", s, bus.out_valid); end
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_saturation();
      bus6.out_ready = 1'b1;
      send_word6(32'hFFFF_FFFF, 1'b0);
      send_word6(32'hFFFF_FFFF, 1'b1);
      n_cmp++; if (bus6.out_count !== CW6'(e_cnt) || e_cnt != 63) begin n_fail++; $display("FAIL sat_count got %0d required 63", bus6.out_count); end
      n_cmp++; if (bus6.out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b required 1", bus6.out_sat); end
      send_word6(32'h0000_0001, 1'b1);
      n_cmp++; if (bus6.out_count !== 6'd1 || bus6.out_sat !== 1'b0) begin
         n_fail++; $display("FAIL sat_next got %0d/%b required 1/0", bus6.out_count, bus6.out_sat);
      end
      step();
      // Word-count saturation on the main instance: 260 words into an 8-bit count.
      bus.out_ready = 1'b1;
      for (int w = 0; w < 260; w++) send_word(rand_word(), w == 259);
      n_cmp++; if (bus.out_words !== LW'(e_words) || bus.out_sat !== e_sat || bus.out_count !== CW'(e_cnt)) begin
         n_fail++; $display("FAIL sat_words got %0d/%b/%0d required %0d/%b/%0d", bus.out_words, bus.out_sat, bus.out_count, e_words, e_sat, e_cnt);
      end
      step();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_word(32'h0000_000F, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_bs    = 32'hFFFF_FFFF;
      bus.in_last  = 1'b1;
      flush        = 1'b1;
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      model_clear();
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_no_result valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
      end
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_still_idle got %b required 0", bus.out_valid); end
      send_word(32'h0000_0003, 1'b1);
      n_cmp++; if (bus.out_count !== 16'd2 || bus.out_words !== 8'd1) begin
         n_fail++; $display("FAIL flush_after got %0d/%0d required 2/1", bus.out_count, bus.out_words);
      end
      step();
      // Flush during HOLD with a simultaneous handshake drops the result.
      bus.out_ready = 1'b0;
      send_word(rand_word(), 1'b1);
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hold got %b required 0", bus.out_valid); end
      send_word(rand_word(), 1'b0);
      send_word(rand_word(), 1'b1);
      n_cmp++; if (bus.out_count !== CW'(e_cnt) || bus.out_words !== LW'(e_words)) begin
         n_fail++; $display("FAIL flush_hold_next got %0d/%0d required %0d/%0d", bus.out_count, bus.out_words, e_cnt, e_words);
      end
      step();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b1;
      send_word(32'hFFFF_FFFF, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_clear();
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== 16'd0 || bus.out_words !== 8'd0 || bus.out_sat !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid got v=%b r=%b %0d/%0d/%b required 0 1 0/0/0", bus.out_valid, bus.in_ready, bus.out_count, bus.out_words, bus.out_sat);
      end
      send_word(32'h0000_0101, 1'b1);
      n_cmp++; if (bus.out_count !== 16'd2 || bus.out_words !== 8'd1) begin
         n_fail++; $display("FAIL rst_mid_next got %0d/%0d required 2/1", bus.out_count, bus.out_words);
      end
      step();
      bus.out_ready = 1'b0;
      send_word(32'hFFFF_FFFF, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== 16'd0 || bus.out_words !== 8'd0) begin
         n_fail++; $display("FAIL rst_hold got v=%b r=%b %0d/%0d required 0 1 0/0", bus.out_valid, bus.in_ready, bus.out_count, bus.out_words);
      end
      send_word(rand_word(), 1'b0);
      send_word(rand_word(), 1'b1);
      n_cmp++; if (bus.out_count !== CW'(e_cnt) || bus.out_words !== LW'(e_words)) begin
         n_fail++; $display("FAIL rst_hold_next got %0d/%0d required %0d/%0d", bus.out_count, bus.out_words, e_cnt, e_words);
      end
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      flush6         = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_bs      = 'x;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b1;
      bus6.in_valid  = 1'b0;
      bus6.in_bs     = 'x;
      bus6.in_last   = 1'b0;
      bus6.out_ready = 1'b1;

      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_random_streams();
      test_saturation();
      test_flush();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
